// File: rtl/motion_seg_pkg.sv
// Constants and helpers shared by the motion-segmentation blocks (morph filter, blob analyzer).
package motion_seg_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 11;

  // One window column: rows centre-1, centre, centre+1.
  typedef struct packed {
    logic top;
    logic mid;
    logic bot;
  } fg_col_t;

  function automatic logic [3:0] popcount9(input logic [8:0] bits);
    logic [3:0] sum;
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      sum = sum + 4'(bits[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/fg_line_buffer.sv
// Two 1-bit line stores holding input rows y-1 and y-2; read-before-write at one address,
// registered read data (1-cycle latency). Contents are never reset.
module fg_line_buffer #(
  parameter int DEPTH  = motion_seg_pkg::H_ACTIVE,
  parameter int ADDR_W = motion_seg_pkg::COORD_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_px,
  output logic              rd_row1,
  output logic              rd_row2
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          row1_mem [DEPTH];
  logic          row2_mem [DEPTH];
  logic          rd_row1_q;
  logic          rd_row2_q;
  logic [AW-1:0] idx;
  logic          in_range;

  assign idx      = addr[AW-1:0];
  assign in_range = (addr < ADDR_W'(DEPTH));

  // Row y-1 ages into row y-2 at the same address as the new pixel lands in row y-1.
  always_ff @(posedge clk) begin
    if (en && in_range) begin
      row1_mem[idx] <= wr_px;
      row2_mem[idx] <= row1_mem[idx];
      rd_row1_q     <= row1_mem[idx];
      rd_row2_q     <= row2_mem[idx];
    end
  end

  assign rd_row1 = rd_row1_q;
  assign rd_row2 = rd_row2_q;

endmodule

// File: rtl/foregnd_morph_filter.sv
// 3x3 binary majority filter on the raw foreground mask. Three stages: input/RAM read,
// window shift, popcount+compare. Centre lags input by one row and one column.
module foregnd_morph_filter #(
  parameter int H_ACTIVE  = motion_seg_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = motion_seg_pkg::V_ACTIVE,
  parameter int MIN_COUNT = 5,
  parameter int COORD_W   = motion_seg_pkg::COORD_W
) (
  input  logic               app_clk,
  input  logic               app_rst,
  input  logic               vid_active_pix,
  input  logic [COORD_W-1:0] vid_hpos,
  input  logic [COORD_W-1:0] vid_vpos,
  input  logic               raw_fg_px,
  output logic               fg_valid,
  output logic               fg_px,
  output logic [COORD_W-1:0] fg_hpos,
  output logic [COORD_W-1:0] fg_vpos
);

  import motion_seg_pkg::*;

  logic               accept;
  logic               rd_row1;
  logic               rd_row2;
  logic               shift;
  fg_col_t            new_col;
  logic [3:0]         win_sum;

  logic               flush_pending_q, flush_pending_d;
  logic               line_seen_q, line_seen_d;
  logic               primed_q, primed_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_flush_q, s1_flush_d;
  logic               s1_px_q, s1_px_d;
  logic [COORD_W-1:0] s1_hpos_q, s1_hpos_d;
  logic [COORD_W-1:0] s1_vpos_q, s1_vpos_d;
  fg_col_t            win_l_q, win_l_d;
  fg_col_t            win_c_q, win_c_d;
  fg_col_t            win_r_q, win_r_d;
  logic               emit_q, emit_d;
  logic [COORD_W-1:0] cx_q, cx_d;
  logic [COORD_W-1:0] cy_q, cy_d;
  logic               fg_valid_q, fg_valid_d;
  logic               fg_px_q, fg_px_d;
  logic [COORD_W-1:0] fg_hpos_q, fg_hpos_d;
  logic [COORD_W-1:0] fg_vpos_q, fg_vpos_d;

  // The flush slot owns stage 0; an active pixel arriving then (source error) is dropped.
  assign accept = vid_active_pix && !flush_pending_q;

  fg_line_buffer #(
    .DEPTH  (H_ACTIVE),
    .ADDR_W (COORD_W)
  ) u_line_buf (
    .clk     (app_clk),
    .en      (accept),
    .addr    (vid_hpos),
    .wr_px   (raw_fg_px),
    .rd_row1 (rd_row1),
    .rd_row2 (rd_row2)
  );

  always_comb begin
    flush_pending_d = accept && (vid_hpos == COORD_W'(H_ACTIVE - 1));
    line_seen_d     = line_seen_q || (accept && (vid_hpos == '0));
    s1_valid_d      = accept;
    s1_flush_d      = flush_pending_q;
    s1_px_d         = s1_px_q;
    s1_hpos_d       = s1_hpos_q;
    s1_vpos_d       = s1_vpos_q;
    if (accept) begin
      s1_px_d   = raw_fg_px;
      s1_hpos_d = vid_hpos;
      s1_vpos_d = vid_vpos;
    end

    // Bottom row is out of frame for input row 0, top row for input row 1.
    new_col.top = rd_row2 && (s1_vpos_q != COORD_W'(1));
    new_col.mid = rd_row1;
    new_col.bot = s1_px_q && (s1_vpos_q != '0);
    if (s1_flush_q) begin
      new_col = '0;
    end

    shift   = s1_valid_q || s1_flush_q;
    win_l_d = win_l_q;
    win_c_d = win_c_q;
    win_r_d = win_r_q;
    if (shift) begin
      win_l_d = win_c_q;
      win_c_d = (s1_valid_q && (s1_hpos_q == '0)) ? fg_col_t'('0) : win_r_q;
      win_r_d = new_col;
    end

    // Stale centre row V_ACTIVE-1 after reset is hidden until row 0 has streamed in full.
    primed_d = primed_q || (s1_flush_q && (s1_vpos_q == '0) && line_seen_q);
    emit_d   = shift && primed_q && (s1_flush_q || (s1_hpos_q != '0));
    cx_d     = s1_flush_q ? s1_hpos_q : s1_hpos_q - COORD_W'(1);
    cy_d     = (s1_vpos_q == '0) ? COORD_W'(V_ACTIVE - 1) : s1_vpos_q - COORD_W'(1);

    win_sum    = popcount9({win_l_q, win_c_q, win_r_q});
    fg_valid_d = emit_q;
    fg_px_d    = emit_q && (win_sum >= 4'(MIN_COUNT));
    fg_hpos_d  = emit_q ? cx_q : fg_hpos_q;
    fg_vpos_d  = emit_q ? cy_q : fg_vpos_q;
  end

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      flush_pending_q <= 1'b0;
      line_seen_q     <= 1'b0;
      primed_q        <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_flush_q      <= 1'b0;
      s1_px_q         <= 1'b0;
      s1_hpos_q       <= '0;
      s1_vpos_q       <= '0;
      win_l_q         <= '0;
      win_c_q         <= '0;
      win_r_q         <= '0;
      emit_q          <= 1'b0;
      cx_q            <= '0;
      cy_q            <= '0;
      fg_valid_q      <= 1'b0;
      fg_px_q         <= 1'b0;
      fg_hpos_q       <= '0;
      fg_vpos_q       <= '0;
    end else begin
      flush_pending_q <= flush_pending_d;
      line_seen_q     <= line_seen_d;
      primed_q        <= primed_d;
      s1_valid_q      <= s1_valid_d;
      s1_flush_q      <= s1_flush_d;
      s1_px_q         <= s1_px_d;
      s1_hpos_q       <= s1_hpos_d;
      s1_vpos_q       <= s1_vpos_d;
      win_l_q         <= win_l_d;
      win_c_q         <= win_c_d;
      win_r_q         <= win_r_d;
      emit_q          <= emit_d;
      cx_q            <= cx_d;
      cy_q            <= cy_d;
      fg_valid_q      <= fg_valid_d;
      fg_px_q         <= fg_px_d;
      fg_hpos_q       <= fg_hpos_d;
      fg_vpos_q       <= fg_vpos_d;
    end
  end

  assign fg_valid = fg_valid_q;
  assign fg_px    = fg_px_q;
  assign fg_hpos  = fg_hpos_q;
  assign fg_vpos  = fg_vpos_q;

endmodule

// File: tb/tb_foregnd_morph_filter.sv
// Bench for foregnd_morph_filter on a reduced 16x8 frame: random and patterned frames,
// a window-sum reference model, a scoreboard queue and per-output latency checks.
module tb_foregnd_morph_filter;

  import motion_seg_pkg::*;

  localparam int TB_H   = 16;
  localparam int TB_V   = 8;
  localparam int TB_MIN = 5;
  localparam int CW     = COORD_W;
  localparam int W      = 2 * CW + 1;

  // clock / reset
  logic          app_clk = 1'b0;
  logic          app_rst = 1'b1;
  logic          vid_active_pix = 1'b0;
  logic [CW-1:0] vid_hpos = '0;
  logic [CW-1:0] vid_vpos = '0;
  logic          raw_fg_px = 1'b0;
  logic          fg_valid;
  logic          fg_px;
  logic [CW-1:0] fg_hpos;
  logic [CW-1:0] fg_vpos;

  always #5 app_clk = ~app_clk;

  int cyc = 0;
  always @(posedge app_clk) cyc = cyc + 1;

  foregnd_morph_filter #(
    .H_ACTIVE  (TB_H),
    .V_ACTIVE  (TB_V),
    .MIN_COUNT (TB_MIN),
    .COORD_W   (CW)
  ) dut (
    .app_clk        (app_clk),
    .app_rst        (app_rst),
    .vid_active_pix (vid_active_pix),
    .vid_hpos       (vid_hpos),
    .vid_vpos       (vid_vpos),
    .raw_fg_px      (raw_fg_px),
    .fg_valid       (fg_valid),
    .fg_px          (fg_px),
    .fg_hpos        (fg_hpos),
    .fg_vpos        (fg_vpos)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           compared   = 0;
  int           mismatched = 0;
  int           rst_req    = 2;
  bit           frame_px [TB_V][TB_H];
  int           done_cyc [TB_V*TB_H];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count ones in the 3x3 neighbourhood, out-of-frame neighbours are zero.
  function automatic bit model_px(input int x, input int y);
    int cnt;
    cnt = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (x + dx >= 0 && x + dx < TB_H && y + dy >= 0 && y + dy < TB_V) begin
          cnt += int'(frame_px[y+dy][x+dx]);
        end
      end
    end
    return cnt >= TB_MIN;
  endfunction

  task automatic push_frame_exp();
    logic [W-1:0] e;
    for (int y = 0; y < TB_V; y++) begin
      for (int x = 0; x < TB_H; x++) begin
        e = {CW'(x), CW'(y), model_px(x, y)};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic set_pattern(input int kind, input int density);
    for (int y = 0; y < TB_V; y++) begin
      for (int x = 0; x < TB_H; x++) begin
        case (kind)
          0:       frame_px[y][x] = (x == 5 && y == 3);
          1:       frame_px[y][x] = (x >= 3 && x <= 12 && y >= 2 && y <= 5);
          2:       frame_px[y][x] = 1'b1;
          3:       frame_px[y][x] = (x == 7);
          4:       frame_px[y][x] = (x >= 11 && x <= 14 && y >= 1 && y <= 5);
          default: frame_px[y][x] = ($urandom_range(0, 99) < density);
        endcase
      end
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge app_clk);
    #1;
    if (app_rst) begin
      exp_q.delete();
      check("rst_fg_valid", 32'(fg_valid), 0);
      check("rst_fg_px", 32'(fg_px), 0);
      check("rst_fg_hpos", 32'(fg_hpos), 0);
      check("rst_fg_vpos", 32'(fg_vpos), 0);
    end
    if (rst_req > 0) begin
      app_rst = 1'b1;
      rst_req--;
    end else begin
      app_rst = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    next_cycle();
    vid_active_pix = 1'b0;
    vid_hpos       = CW'($urandom_range(0, 2 * TB_H));
    vid_vpos       = CW'($urandom_range(0, 2 * TB_V));
    raw_fg_px      = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_px(input int x, input int y);
    int cy;
    next_cycle();
    vid_active_pix = 1'b1;
    vid_hpos       = CW'(x);
    vid_vpos       = CW'(y);
    raw_fg_px      = frame_px[y][x];
    cy = (y == 0) ? TB_V - 1 : y - 1;
    if (x >= 1) done_cyc[cy*TB_H + x - 1] = cyc + 3;
    if (x == TB_H - 1) done_cyc[cy*TB_H + x] = cyc + 4;
  endtask

  task automatic drive_row(input int y, input int rst_x);
    for (int x = 0; x < TB_H; x++) begin
      if ($urandom_range(0, 5) == 0) idle_cycle();
      if (x == rst_x) rst_req = 2;
      drive_px(x, y);
    end
    repeat ($urandom_range(1, 4)) idle_cycle();
  endtask

  task automatic drive_frame(input int kind, input int density, input int rst_y, input int rst_x);
    set_pattern(kind, density);
    push_frame_exp();
    for (int y = 0; y < TB_V; y++) begin
      drive_row(y, (y == rst_y) ? rst_x : -1);
    end
  endtask

  // monitor
  always @(negedge app_clk) begin
    logic [W-1:0] e;
    int           ex;
    int           ey;
    if (fg_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: got (%0d,%0d) px=%0d, want no output", fg_hpos, fg_vpos, fg_px);
      end else begin
        e  = exp_q.pop_front();
        ex = int'(e[W-1 -: CW]);
        ey = int'(e[CW:1]);
        check("fg_hpos", 32'(fg_hpos), 32'(ex));
        check("fg_vpos", 32'(fg_vpos), 32'(ey));
        check("fg_px", 32'(fg_px), 32'(e[0]));
        check("latency", 32'(cyc), 32'(done_cyc[ey*TB_H + ex]));
      end
    end
  end

  // stimulus
  initial begin
    drive_frame(0, 0, -1, -1);
    drive_frame(1, 0, -1, -1);
    drive_frame(2, 0, -1, -1);
    drive_frame(3, 0, -1, -1);
    drive_frame(4, 0, -1, -1);
    drive_frame(5, 30, -1, -1);
    drive_frame(5, 50, -1, -1);
    drive_frame(5, 70, -1, -1);
    drive_frame(1, 0, 5, 8);
    drive_frame(1, 0, -1, -1);
    drive_frame(5, 50, -1, -1);
    // One trailing row 0 drains the last frame's bottom centre row.
    set_pattern(5, 50);
    drive_row(0, -1);
    repeat (10) idle_cycle();
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
